// File: rtl/clk_ratio_det.sv
// rtl/clk_ratio_det.sv - divided-clock period detector reporting ratio, lock, change and timeout
// Optional expected-ratio compare (exp_ratio/o_mismatch) under `define CLK_RATIO_DET_CMP_EN.

module clk_ratio_det #(
    parameter int RATIO_WID = 8,
    parameter int LOCK_CNT  = 4
) (
    input  logic                 i_clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 div_clk,
`ifdef CLK_RATIO_DET_CMP_EN
    input  logic [RATIO_WID-1:0] exp_ratio,
    output logic                 o_mismatch,
`endif
    output logic [RATIO_WID-1:0] o_ratio,
    output logic                 o_vld,
    output logic                 o_err,
    output logic                 o_ovf
);
    localparam int CW = RATIO_WID + 1;
    localparam logic [CW-1:0] CNT_TOP = {1'b1, {RATIO_WID{1'b0}}};
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_SAT = CNT_TOP + CNT_ONE;
    localparam logic [3:0]    LOCK_V  = 4'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, SYNC, MEASURE, LOCKED} state_t;

    state_t               state_q, state_d;
    logic                 d1_q, d1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [RATIO_WID-1:0] cand_q, cand_d;
    logic [3:0]           match_q, match_d;
    logic [RATIO_WID-1:0] ratio_q, ratio_d;
    logic                 vld_q, vld_d;
    logic                 err_q, err_d;
    logic                 ovf_q, ovf_d;
    logic                 rise;
    logic                 timeout;
    logic [RATIO_WID-1:0] p;

    assign rise    = div_clk & ~d1_q;
    assign p       = cnt_q[RATIO_WID-1:0];
    // A rise at cnt==2^W is a valid maximum period; only its absence times out.
    assign timeout = ~rise && (cnt_q == CNT_TOP);

    always_comb begin
        state_d = state_q;
        d1_d    = div_clk;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        match_d = match_q;
        ratio_d = ratio_q;
        vld_d   = vld_q;
        err_d   = 1'b0;
        ovf_d   = 1'b0;

        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            cand_d  = '0;
            match_d = '0;
            ratio_d = '0;
            vld_d   = 1'b0;
        end else begin
            if (rise) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_ONE;
            end

            unique case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = SYNC;
                end
                SYNC: begin
                    if (rise) begin
                        state_d = MEASURE;
                        match_d = '0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        if (match_q == 4'd0 || p != cand_q) begin
                            cand_d  = p;
                            match_d = 4'd1;
                        end else begin
                            match_d = match_q + 4'd1;
                            if (match_q + 4'd1 == LOCK_V) begin
                                state_d = LOCKED;
                                vld_d   = 1'b1;
                                ratio_d = cand_q;
                            end
                        end
                    end else if (timeout) begin
                        state_d = SYNC;
                        ovf_d   = 1'b1;
                        vld_d   = 1'b0;
                        ratio_d = '0;
                    end
                end
                LOCKED: begin
                    if (rise) begin
                        if (p != ratio_q) begin
                            state_d = MEASURE;
                            err_d   = 1'b1;
                            vld_d   = 1'b0;
                            ratio_d = '0;
                            cand_d  = p;
                            match_d = 4'd1;
                        end
                    end else if (timeout) begin
                        state_d = SYNC;
                        ovf_d   = 1'b1;
                        vld_d   = 1'b0;
                        ratio_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q <= IDLE;
            d1_q    <= 1'b0;
            cnt_q   <= '0;
            cand_q  <= '0;
            match_q <= '0;
            ratio_q <= '0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            d1_q    <= d1_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            match_q <= match_d;
            ratio_q <= ratio_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_ratio = ratio_q;
    assign o_vld   = vld_q;
    assign o_err   = err_q;
    assign o_ovf   = ovf_q;

`ifdef CLK_RATIO_DET_CMP_EN
    logic mis_q, mis_d;

    always_comb begin
        mis_d = en & vld_q & (ratio_q != exp_ratio);
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= mis_d;
        end
    end

    assign o_mismatch = mis_q;
`endif

endmodule

// File: tb/tb_clk_ratio_det.sv
// tb/tb_clk_ratio_det.sv - directed self-checking bench for clk_ratio_det
// Compare scenario runs only when CLK_RATIO_DET_CMP_EN is defined.

module tb_clk_ratio_det;
    logic       i_clk = 1'b0;
    logic       rst;
    logic       en;
    logic       div_clk;
    logic [7:0] o_ratio;
    logic       o_vld;
    logic       o_err;
    logic       o_ovf;
`ifdef CLK_RATIO_DET_CMP_EN
    logic [7:0] exp_ratio;
    logic       o_mismatch;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int period = 4;
    int ph = 0;
    bit div_run = 1'b0;
    bit rise_now = 1'b0;

    always #5 i_clk = ~i_clk;

    clk_ratio_det #(.RATIO_WID(8), .LOCK_CNT(4)) dut (
        .i_clk      (i_clk),
        .rst        (rst),
        .en         (en),
        .div_clk    (div_clk),
`ifdef CLK_RATIO_DET_CMP_EN
        .exp_ratio  (exp_ratio),
        .o_mismatch (o_mismatch),
`endif
        .o_ratio    (o_ratio),
        .o_vld      (o_vld),
        .o_err      (o_err),
        .o_ovf      (o_ovf)
    );

    // Advance one i_clk cycle, then drive the next divided-clock sample.
    task automatic tick();
        logic prev;
        @(posedge i_clk);
        #1;
        prev = div_clk;
        if (div_run) begin
            ph      = (ph >= period - 1) ? 0 : ph + 1;
            div_clk = (ph < period / 2);
        end else begin
            div_clk = 1'b0;
        end
        rise_now = div_clk & ~prev;
    endtask

    task automatic start_div(input int per);
        period  = per;
        ph      = per - 1;
        div_run = 1'b1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        div_run = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_lock(input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            tick();
            if (o_vld) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rise(input int bound, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            tick();
            if (rise_now) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        div_clk = 1'b0;
        div_run = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (o_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %0b exp 0", o_vld); end
        n_cmp++;
        if (o_ratio !== 8'd0) begin n_bad++; $display("FAIL reset_ratio got %0d exp 0", o_ratio); end
        n_cmp++;
        if (o_err !== 1'b0 || o_ovf !== 1'b0) begin
            n_bad++; $display("FAIL reset_pulses got err=%0b ovf=%0b exp 0/0", o_err, o_ovf);
        end
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_ratio4();
        start_div(4);
        tick();
        n_cmp++;
        if (rise_now !== 1'b1) begin n_bad++; $display("FAIL t1_stim_rise got %0b exp 1", rise_now); end
        for (int k = 1; k <= 16; k++) tick();
        n_cmp++;
        if (o_vld !== 1'b0) begin n_bad++; $display("FAIL t1_vld_early got %0b exp 0", o_vld); end
        tick();
        n_cmp++;
        if (o_vld !== 1'b1) begin n_bad++; $display("FAIL t1_vld_lock got %0b exp 1", o_vld); end
        n_cmp++;
        if (o_ratio !== 8'd4) begin n_bad++; $display("FAIL t1_ratio got %0d exp 4", o_ratio); end
    endtask

    task automatic test_ratio256();
        int first_vld = -1;
        bit saw_ovf = 1'b0;
        logic [7:0] lock_ratio = 8'hff;
        do_reset();
        start_div(256);
        tick();
        for (int k = 1; k <= 1030; k++) begin
            tick();
            if (o_ovf) saw_ovf = 1'b1;
            if (o_vld && first_vld < 0) begin
                first_vld  = k;
                lock_ratio = o_ratio;
            end
        end
        n_cmp++;
        if (first_vld != 1025) begin n_bad++; $display("FAIL t2_lock_time got %0d exp 1025", first_vld); end
        n_cmp++;
        if (lock_ratio !== 8'd0) begin n_bad++; $display("FAIL t2_ratio got %0d exp 0", lock_ratio); end
        n_cmp++;
        if (saw_ovf !== 1'b0) begin n_bad++; $display("FAIL t2_no_ovf got %0b exp 0", saw_ovf); end
    endtask

    task automatic test_ratio_change();
        bit ok;
        int n_err = 0;
        do_reset();
        start_div(4);
        wait_lock(40, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL t3_lock4 got no lock exp lock"); end
        wait_rise(8, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL t3_rise got none exp rise"); end
        period = 6;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (o_err) n_err++;
            if (k == 6) begin
                n_cmp++;
                if (o_vld !== 1'b1) begin n_bad++; $display("FAIL t3_vld_hold got %0b exp 1", o_vld); end
            end
            if (k == 7) begin
                n_cmp++;
                if (o_err !== 1'b1) begin n_bad++; $display("FAIL t3_err got %0b exp 1", o_err); end
                n_cmp++;
                if (o_vld !== 1'b0 || o_ratio !== 8'd0) begin
                    n_bad++; $display("FAIL t3_unlock got vld=%0b ratio=%0d exp 0/0", o_vld, o_ratio);
                end
            end
            if (k == 24) begin
                n_cmp++;
                if (o_vld !== 1'b0) begin n_bad++; $display("FAIL t3_relock_early got %0b exp 0", o_vld); end
            end
        end
        n_cmp++;
        if (o_vld !== 1'b1 || o_ratio !== 8'd6) begin
            n_bad++; $display("FAIL t3_relock got vld=%0b ratio=%0d exp 1/6", o_vld, o_ratio);
        end
        n_cmp++;
        if (n_err != 1) begin n_bad++; $display("FAIL t3_err_count got %0d exp 1", n_err); end
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        start_div(8);
        wait_lock(80, ok);
        n_cmp++;
        if (!ok || o_ratio !== 8'd8) begin
            n_bad++; $display("FAIL t4_lock8 got vld=%0b ratio=%0d exp 1/8", o_vld, o_ratio);
        end
        wait_rise(10, ok);
        div_run = 1'b0;
        for (int k = 1; k <= 256; k++) tick();
        n_cmp++;
        if (o_ovf !== 1'b0 || o_vld !== 1'b1) begin
            n_bad++; $display("FAIL t4_pre_ovf got ovf=%0b vld=%0b exp 0/1", o_ovf, o_vld);
        end
        tick();
        n_cmp++;
        if (o_ovf !== 1'b1) begin n_bad++; $display("FAIL t4_ovf got %0b exp 1", o_ovf); end
        n_cmp++;
        if (o_vld !== 1'b0 || o_ratio !== 8'd0 || o_err !== 1'b0) begin
            n_bad++; $display("FAIL t4_unlock got vld=%0b ratio=%0d err=%0b exp 0/0/0", o_vld, o_ratio, o_err);
        end
        tick();
        n_cmp++;
        if (o_ovf !== 1'b0) begin n_bad++; $display("FAIL t4_ovf_width got %0b exp 0", o_ovf); end
        start_div(8);
        tick();
        for (int k = 1; k <= 32; k++) tick();
        n_cmp++;
        if (o_vld !== 1'b0) begin n_bad++; $display("FAIL t4_resync_early got %0b exp 0", o_vld); end
        tick();
        n_cmp++;
        if (o_vld !== 1'b1 || o_ratio !== 8'd8) begin
            n_bad++; $display("FAIL t4_resync got vld=%0b ratio=%0d exp 1/8", o_vld, o_ratio);
        end
    endtask

    task automatic test_mid_reset();
        bit ok = 1'b0;
        int n_err = 0;
        rst = 1'b1;
        tick();
        n_cmp++;
        if (o_vld !== 1'b0 || o_ratio !== 8'd0 || o_err !== 1'b0 || o_ovf !== 1'b0) begin
            n_bad++; $display("FAIL t5_reset got vld=%0b ratio=%0d err=%0b ovf=%0b exp 0", o_vld, o_ratio, o_err, o_ovf);
        end
        rst = 1'b0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (o_err || o_ovf) n_err++;
            if (o_vld) begin ok = 1'b1; break; end
        end
        n_cmp++;
        if (!ok || o_ratio !== 8'd8) begin
            n_bad++; $display("FAIL t5_relock got vld=%0b ratio=%0d exp 1/8", o_vld, o_ratio);
        end
        n_cmp++;
        if (n_err != 0) begin n_bad++; $display("FAIL t5_no_pulse got %0d exp 0", n_err); end
    endtask

    task automatic test_en_drop();
        bit ok;
        en = 1'b0;
        tick();
        n_cmp++;
        if (o_vld !== 1'b0 || o_ratio !== 8'd0 || o_err !== 1'b0 || o_ovf !== 1'b0) begin
            n_bad++; $display("FAIL en_drop got vld=%0b ratio=%0d err=%0b ovf=%0b exp 0", o_vld, o_ratio, o_err, o_ovf);
        end
        for (int k = 0; k < 20; k++) tick();
        n_cmp++;
        if (o_vld !== 1'b0 || o_err !== 1'b0 || o_ovf !== 1'b0) begin
            n_bad++; $display("FAIL en_idle got vld=%0b err=%0b ovf=%0b exp 0", o_vld, o_err, o_ovf);
        end
        en = 1'b1;
        wait_lock(80, ok);
        n_cmp++;
        if (!ok || o_ratio !== 8'd8) begin
            n_bad++; $display("FAIL en_relock got vld=%0b ratio=%0d exp 1/8", o_vld, o_ratio);
        end
    endtask

`ifdef CLK_RATIO_DET_CMP_EN
    task automatic test_compare();
        bit ok;
        exp_ratio = 8'd5;
        do_reset();
        start_div(5);
        wait_lock(60, ok);
        tick();
        tick();
        n_cmp++;
        if (!ok || o_mismatch !== 1'b0) begin
            n_bad++; $display("FAIL t6_match got lock=%0b mis=%0b exp 1/0", ok, o_mismatch);
        end
        wait_rise(10, ok);
        period = 7;
        for (int k = 0; k < 3; k++) tick();
        wait_lock(60, ok);
        n_cmp++;
        if (!ok || o_ratio !== 8'd7 || o_mismatch !== 1'b0) begin
            n_bad++; $display("FAIL t6_relock got ratio=%0d mis=%0b exp 7/0", o_ratio, o_mismatch);
        end
        tick();
        n_cmp++;
        if (o_mismatch !== 1'b1) begin n_bad++; $display("FAIL t6_mismatch got %0b exp 1", o_mismatch); end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        div_clk = 1'b0;
`ifdef CLK_RATIO_DET_CMP_EN
        exp_ratio = 8'd0;
`endif
        test_reset();
        test_ratio4();
        test_ratio256();
        test_ratio_change();
        test_timeout();
        test_mid_reset();
        test_en_drop();
`ifdef CLK_RATIO_DET_CMP_EN
        test_compare();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
